// File: rtl/c3_heap_cmd_issuer.sv
// Queues host push/pop commands and issues them one at a time to the C3 heap unit.
// Keeps a shadow heap size and turns each tagged completion into a host response.
module c3_heap_cmd_issuer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned HEAP_CAP  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_v,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_data,
  output logic        rsp_v,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        hp_in_v,
  output logic [4:0]  hp_rd,
  output logic [2:0]  hp_vrd1,
  output logic [2:0]  hp_vrd2,
  output logic [31:0] hp_in_data,
  output logic [31:0] hp_in_heap_addr,
  output logic [31:0] hp_in_heap_size,
  input  logic        hp_out_v,
  input  logic [4:0]  hp_out_rd,
  input  logic [31:0] hp_out_data,
  input  logic [31:0] hp_out_heap_size,
  output logic [31:0] heap_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   CntFull     = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CntOne      = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne      = AW'(1);
  localparam logic [7:0]    TimeoutLast = 8'(TIMEOUT - 1);
  localparam logic [31:0]   HeapCap     = 32'(HEAP_CAP);
  localparam logic [1:0]    OpPush      = 2'b00;
  localparam logic [1:0]    OpPop       = 2'b01;

  typedef enum logic [2:0] {StIdle, StCheck, StIssue, StWait, StResp} state_e;

  state_e state_q, state_d;

  logic [33:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          req_ready_q;
  logic          push_en, pop_en;

  logic [1:0]  hold_op_q;
  logic [31:0] hold_data_q;
  logic [7:0]  wait_cnt_q;
  logic [4:0]  tag_q;
  logic [31:0] size_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;
  logic        check_err, accept, timed_out;

  assign push_en   = req_v && req_ready_q;
  assign pop_en    = (state_q == StIdle) && (count_q != '0);
  assign check_err = hold_op_q[1] ||
                     ((hold_op_q == OpPush) && (size_q >= HeapCap)) ||
                     ((hold_op_q == OpPop) && (size_q == '0));
  assign accept    = (state_q == StWait) && hp_out_v && (hp_out_rd == tag_q);
  assign timed_out = (state_q == StWait) && !accept && (wait_cnt_q == TimeoutLast);

  always_comb begin
    count_d = count_q;
    if (push_en && !pop_en) begin
      count_d = count_q + CntOne;
    end else if (!push_en && pop_en) begin
      count_d = count_q - CntOne;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      fifo_mem[wr_ptr_q] <= {req_op, req_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      req_ready_q <= 1'b1;
      hold_op_q   <= '0;
      hold_data_q <= '0;
      wait_cnt_q  <= '0;
      tag_q       <= '0;
      size_q      <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (push_en) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop_en) begin
        hold_op_q   <= fifo_mem[rd_ptr_q][33:32];
        hold_data_q <= fifo_mem[rd_ptr_q][31:0];
        rd_ptr_q    <= rd_ptr_q + PtrOne;
      end
      count_q     <= count_d;
      // Registered from next occupancy, so a same-cycle dequeue re-opens it one cycle later.
      req_ready_q <= (count_d != CntFull);

      if (state_q == StIssue) begin
        wait_cnt_q <= '0;
      end else if (state_q == StWait) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end

      if ((state_q == StCheck) && check_err) begin
        rsp_err_q  <= 1'b1;
        rsp_data_q <= '0;
      end
      if (accept) begin
        size_q     <= hp_out_heap_size;
        rsp_data_q <= (hold_op_q == OpPop) ? hp_out_data : '0;
        rsp_err_q  <= 1'b0;
      end else if (timed_out) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b1;
      end

      if ((state_q == StResp) && rsp_ready) begin
        tag_q <= tag_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (count_q != '0) state_d = StCheck;
      StCheck: state_d = check_err ? StResp : StIssue;
      StIssue: state_d = StWait;
      StWait:  if (accept || timed_out) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready       = req_ready_q;
    rsp_v           = (state_q == StResp);
    rsp_data        = rsp_v ? rsp_data_q : '0;
    rsp_err         = rsp_v && rsp_err_q;
    hp_in_v         = (state_q == StIssue);
    hp_rd           = hp_in_v ? tag_q : '0;
    hp_vrd1         = hp_in_v ? {2'b00, hold_op_q[0]} : 3'b000;
    hp_vrd2         = 3'b000;
    hp_in_data      = (hp_in_v && (hold_op_q == OpPush)) ? hold_data_q : '0;
    hp_in_heap_addr = BASE_ADDR;
    hp_in_heap_size = hp_in_v ? size_q : '0;
    heap_count      = size_q;
  end

endmodule

// File: tb/tb_c3_heap_cmd_issuer.sv
// Bench for c3_heap_cmd_issuer: directed and random command streams against an in-order
// reference model, with a behavioural max-heap standing in for the heap unit.
module tb_c3_heap_cmd_issuer;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned HEAP_CAP  = 4;
  localparam logic [31:0] BASE_ADDR = 32'h0000_1000;
  localparam int unsigned TIMEOUT   = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_v, req_ready, rsp_v, rsp_ready, rsp_err, hp_in_v, hp_out_v;
  logic [1:0]  req_op;
  logic [31:0] req_data, rsp_data, hp_in_data, hp_in_heap_addr, hp_in_heap_size;
  logic [31:0] hp_out_data, hp_out_heap_size, heap_count;
  logic [4:0]  hp_rd, hp_out_rd;
  logic [2:0]  hp_vrd1, hp_vrd2;

  always #5 clk = ~clk;

  c3_heap_cmd_issuer #(
    .DEPTH(DEPTH), .HEAP_CAP(HEAP_CAP), .BASE_ADDR(BASE_ADDR), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_v(req_v), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .rsp_v(rsp_v), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .hp_in_v(hp_in_v), .hp_rd(hp_rd), .hp_vrd1(hp_vrd1), .hp_vrd2(hp_vrd2),
    .hp_in_data(hp_in_data), .hp_in_heap_addr(hp_in_heap_addr),
    .hp_in_heap_size(hp_in_heap_size),
    .hp_out_v(hp_out_v), .hp_out_rd(hp_out_rd), .hp_out_data(hp_out_data),
    .hp_out_heap_size(hp_out_heap_size), .heap_count(heap_count)
  );

  typedef struct { logic [1:0] op; logic [31:0] data; } req_t;
  typedef struct { logic err; logic [31:0] data; logic [31:0] cnt; } rsp_t;
  typedef struct { logic [4:0] tag; logic [2:0] vrd1; logic [31:0] data; logic [31:0] size; } iss_t;

  int total = 0;
  int bad = 0;
  req_t req_q[$];
  rsp_t exp_rsp_q[$];
  iss_t exp_iss_q[$];
  logic [31:0] mh[$];        // reference heap contents
  logic [31:0] env_heap[$];  // contents held by the emulated heap unit
  int m_tag = 0;
  bit silent = 0;
  bit rand_gap = 0;
  int rdy_mode = 1;          // 0 hold low, 1 always ready, 2 random
  int cyc = 0, hs_cyc = 0, iss_cyc = 0, rsp_cyc = 0;
  bit rsp_v_prev = 0;
  bit reply_due = 0;
  logic [4:0]  reply_tag;
  logic [31:0] reply_data, reply_size;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mh_max_idx();
    int k = 0;
    for (int j = 1; j < mh.size(); j++) if (mh[j] > mh[k]) k = j;
    return k;
  endfunction

  function automatic int env_max_idx();
    int k = 0;
    for (int j = 1; j < env_heap.size(); j++) if (env_heap[j] > env_heap[k]) k = j;
    return k;
  endfunction

  // Commands execute strictly in acceptance order, so results are known at acceptance.
  task automatic model_accept(input req_t r);
    rsp_t e;
    iss_t i;
    int k;
    e.err = 1'b0;
    e.data = '0;
    if (r.op[1] || (r.op == 2'd0 && mh.size() == int'(HEAP_CAP)) ||
        (r.op == 2'd1 && mh.size() == 0)) begin
      e.err = 1'b1;
    end else begin
      i.tag  = 5'(m_tag);
      i.vrd1 = {2'b00, r.op[0]};
      i.data = (r.op == 2'd0) ? r.data : '0;
      i.size = 32'(mh.size());
      exp_iss_q.push_back(i);
      if (silent) e.err = 1'b1;
      else if (r.op == 2'd0) mh.push_back(r.data);
      else begin
        k = mh_max_idx();
        e.data = mh[k];
        mh.delete(k);
      end
    end
    e.cnt = 32'(mh.size());
    exp_rsp_q.push_back(e);
    m_tag = (m_tag + 1) % 32;
  endtask

  task automatic step();
    req_t r;
    iss_t ei;
    int k;
    @(negedge clk);
    cyc++;
    hp_out_v = 1'b0;
    if (reply_due) begin
      hp_out_v = 1'b1;
      hp_out_rd = reply_tag;
      hp_out_data = reply_data;
      hp_out_heap_size = reply_size;
      reply_due = 0;
    end
    if (hp_in_v) begin
      iss_cyc = cyc;
      if (exp_iss_q.size() == 0) check("unexpected_issue", 32'(hp_rd), 32'hffff_ffff);
      else begin
        ei = exp_iss_q.pop_front();
        check("iss_tag", 32'(hp_rd), 32'(ei.tag));
        check("iss_vrd1", 32'(hp_vrd1), 32'(ei.vrd1));
        check("iss_vrd2", 32'(hp_vrd2), 32'd0);
        check("iss_data", hp_in_data, ei.data);
        check("iss_size", hp_in_heap_size, ei.size);
        check("iss_addr", hp_in_heap_addr, BASE_ADDR);
      end
      reply_due = 1;
      reply_data = '0;
      if (silent) begin
        reply_tag = hp_rd + 5'd1;
        reply_data = 32'hdead_beef;
        reply_size = 32'h0000_00ff;
      end else begin
        reply_tag = hp_rd;
        if (hp_vrd1 == 3'd0) env_heap.push_back(hp_in_data);
        else if (env_heap.size() != 0) begin
          k = env_max_idx();
          reply_data = env_heap[k];
          env_heap.delete(k);
        end
        reply_size = 32'(env_heap.size());
      end
    end
    if (rsp_v && !rsp_v_prev) rsp_cyc = cyc;
    rsp_v_prev = rsp_v;
    if (rsp_v) begin
      if (exp_rsp_q.size() == 0) check("unexpected_rsp", 32'(rsp_v), 32'd0);
      else begin
        check("rsp_err", 32'(rsp_err), 32'(exp_rsp_q[0].err));
        check("rsp_data", rsp_data, exp_rsp_q[0].data);
        check("heap_count", heap_count, exp_rsp_q[0].cnt);
      end
    end
    rsp_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 2) != 0);
    if (rsp_v && rsp_ready && exp_rsp_q.size() != 0) void'(exp_rsp_q.pop_front());
    if (req_q.size() != 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
      req_v = 1'b1;
      req_op = req_q[0].op;
      req_data = req_q[0].data;
      if (req_ready) begin
        r = req_q.pop_front();
        model_accept(r);
        hs_cyc = cyc;
      end
    end else begin
      req_v = 1'b0;
      req_op = 2'($urandom);
      req_data = $urandom;
    end
  endtask

  task automatic enq(input logic [1:0] op, input logic [31:0] data);
    req_t r;
    r.op = op;
    r.data = data;
    req_q.push_back(r);
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n = 0;
    while ((req_q.size() != 0 || exp_rsp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 32'(req_q.size() + exp_rsp_q.size() + exp_iss_q.size()), 32'd0);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] old_tag;
    req_t r;
    reset = 1'b1;
    req_v = 1'b0;
    req_op = '0;
    req_data = '0;
    rsp_ready = 1'b0;
    hp_out_v = 1'b0;
    hp_out_rd = '0;
    hp_out_data = '0;
    hp_out_heap_size = '0;
    repeat (3) step();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_v", 32'(rsp_v), 32'd0);
    check("rst_hp_in_v", 32'(hp_in_v), 32'd0);
    check("rst_addr", hp_in_heap_addr, BASE_ADDR);
    check("rst_count", heap_count, 32'd0);
    reset = 1'b0;

    // Single push: issue at N+3, response one cycle after completion.
    enq(2'd0, 32'd10);
    run_idle("push10", 40);
    check("issue_latency", 32'(iss_cyc - hs_cyc), 32'd3);
    check("rsp_latency", 32'(rsp_cyc - iss_cyc), 32'd2);
    enq(2'd0, 32'd20);
    enq(2'd0, 32'd15);
    run_idle("push20_15", 60);
    check("count_after_pushes", heap_count, 32'd3);
    enq(2'd1, 32'd0);
    run_idle("pop20", 40);
    check("count_after_pop", heap_count, 32'd2);

    // Reserved op is refused locally.
    enq(2'd3, 32'd5);
    run_idle("reserved", 40);
    check("err_latency", 32'(rsp_cyc - hs_cyc), 32'd3);

    // Fill to capacity, then overflow.
    enq(2'd0, 32'd7);
    enq(2'd0, 32'd8);
    enq(2'd0, 32'd9);
    run_idle("overflow", 80);
    check("count_at_cap", heap_count, 32'(HEAP_CAP));

    // Heap never answers properly (mismatched tag only): timeout.
    silent = 1;
    enq(2'd1, 32'd0);
    run_idle("timeout", 60);
    check("timeout_latency", 32'(rsp_cyc - iss_cyc), 32'(TIMEOUT + 1));
    check("count_after_timeout", heap_count, 32'(HEAP_CAP));
    silent = 0;

    // Stall responses: FIFO fills, sixth request stays outside.
    rdy_mode = 0;
    repeat (4) enq(2'd1, 32'd0);
    enq(2'd1, 32'd0);
    enq(2'd0, 32'd42);
    repeat (30) step();
    check("full_req_ready", 32'(req_ready), 32'd0);
    check("full_pending", 32'(req_q.size()), 32'd1);
    check("full_rsp_held", 32'(rsp_v), 32'd1);
    rdy_mode = 1;
    run_idle("drain", 200);

    // Random traffic with idle gaps and random response back-pressure.
    rand_gap = 1;
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      r.data = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: r.op = 2'd0;
        5, 6, 7, 8:    r.op = 2'd1;
        default:       r.op = 2'($urandom_range(2, 3));
      endcase
      enq(r.op, r.data);
    end
    run_idle("random", 3000);

    // Reset while waiting on the heap; a stale completion must be ignored.
    rand_gap = 0;
    rdy_mode = 1;
    silent = 1;
    enq((mh.size() < int'(HEAP_CAP)) ? 2'd0 : 2'd1, 32'd77);
    for (int n = 0; n < 12 && (req_q.size() != 0 || exp_iss_q.size() != 0); n++) step();
    check("reached_wait", 32'(exp_iss_q.size() + req_q.size()), 32'd0);
    step();
    old_tag = 5'(m_tag + 31);
    reset = 1'b1;
    step();
    check("mid_rst_rsp_v", 32'(rsp_v), 32'd0);
    check("mid_rst_hp_in_v", 32'(hp_in_v), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_count", heap_count, 32'd0);
    check("mid_rst_rsp_data", rsp_data, 32'd0);
    check("mid_rst_addr", hp_in_heap_addr, BASE_ADDR);
    exp_rsp_q.delete();
    exp_iss_q.delete();
    mh.delete();
    env_heap.delete();
    m_tag = 0;
    silent = 0;
    reset = 1'b0;
    reply_due = 1;
    reply_tag = old_tag;
    reply_data = 32'h1234;
    reply_size = 32'd5;
    repeat (20) step();
    check("stale_count", heap_count, 32'd0);
    check("stale_no_rsp", 32'(rsp_v), 32'd0);

    // Recovery after reset starts again at tag 0.
    enq(2'd0, 32'd99);
    run_idle("recover", 40);
    check("recover_count", heap_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/c3_heap_cmd_issuer.md
# c3_heap_cmd_issuer

Initiator for the C3 custom heap instruction port. Accepts push/pop requests from a host over a valid/ready channel and buffers them in a small command FIFO. Issues them one at a time as single-cycle heap instructions (`vrd1` opcode, data, heap base/size), then waits for the heap unit's tagged `out_v` completion and returns pop data or an error on a response channel. Sits between the core-side command source and the heap execution unit, and keeps a shadow of the heap size.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries (power of two, ≥2)
- `HEAP_CAP`, 16: maximum heap entries; push is refused at this size
- `BASE_ADDR`, 32'h0000_1000: value driven on `hp_in_heap_addr`
- `TIMEOUT`, 15: cycles allowed in WAIT before abort (1..255)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `req_v` in 1: host request valid
- `req_ready` out 1: command FIFO not full
- `req_op` in 2: 00 push, 01 pop, 10/11 reserved
- `req_data` in 32: push value; ignored for pop
- `rsp_v` out 1: response valid, held until accepted
- `rsp_ready` in 1: host accepts response
- `rsp_data` out 32: popped value; 0 on push or error
- `rsp_err` out 1: overflow, underflow, reserved op, or timeout
- `hp_in_v` out 1: heap instruction valid, one-cycle pulse
- `hp_rd` out 5: transaction tag
- `hp_vrd1` out 3: 000 push, 001 pop
- `hp_vrd2` out 3: always 000
- `hp_in_data` out 32: push operand; 0 for pop
- `hp_in_heap_addr` out 32: `BASE_ADDR`
- `hp_in_heap_size` out 32: shadow size at issue
- `hp_out_v` in 1: heap completion
- `hp_out_rd` in 5: completion tag
- `hp_out_data` in 32: popped value
- `hp_out_heap_size` in 32: heap size after the op
- `heap_count` out 32: shadow heap size

## Operation
- Reset values: all outputs 0, except `req_ready`=1 and `hp_in_heap_addr`=`BASE_ADDR`. Reset also empties the FIFO, puts the FSM in IDLE, sets tag 0 and shadow size 0.
- Reset in mid-operation discards any in-flight operation with no response. A late `hp_out_v` after reset is ignored because the FSM is not in WAIT.
- FIFO write condition: `req_v && req_ready`. Entry is {op, data}.
- FSM: IDLE → CHECK → ISSUE → WAIT → RESP → IDLE.
- IDLE: when the FIFO is non-empty, dequeue the head into a holding register and go to CHECK.
- CHECK:
  - reserved op → RESP with err=1
  - push with size==`HEAP_CAP` → RESP with err=1
  - pop with size==0 → RESP with err=1
  - otherwise → ISSUE
  - Error cases never drive `hp_in_v`.
- ISSUE: drive `hp_in_v`=1 for exactly one cycle with the tag, opcode and operands, then go to WAIT.
- WAIT: accept completion only when `hp_out_v && hp_out_rd==tag`.
  - On accept: shadow size ← `hp_out_heap_size`; capture `hp_out_data` for pop (0 for push); err=0; go to RESP.
  - A non-matching tag or `hp_out_v` in any other state is ignored.
  - A cycle counter counts cycles in WAIT. When it reaches `TIMEOUT` with no accept: go to RESP with err=1, shadow size unchanged.
- RESP: `rsp_v`=1 with `rsp_data`/`rsp_err` stable until `rsp_ready`. On handshake: tag increments (5-bit wrap 31→0), go to IDLE.
- Only one heap operation is ever outstanding. Requests keep queueing in the FIFO during WAIT/RESP.
- `heap_count` always mirrors the shadow size.

## Timing
- `req_ready` is registered from FIFO occupancy. It is low when the FIFO is full.
  - A simultaneous dequeue does not re-open `req_ready` in the same cycle; it is high the next cycle.
- Latency is counted from cycle N, the request handshake into an empty FIFO with the FSM idle:
  - dequeue at N+1 (IDLE)
  - CHECK at N+2
  - `hp_in_v` high in cycle N+3
- A completion arriving in cycle M gives `rsp_v` high in cycle M+1.
- Error responses (overflow/underflow/reserved) give `rsp_v` at N+3, with no heap traffic.
- Back-to-back operations: the next IDLE dequeue occurs in the cycle after the `rsp_v`/`rsp_ready` handshake.
- Timeout: `rsp_v` goes high `TIMEOUT`+1 cycles after the ISSUE cycle.

## Test plan
- Push 10, 20, 15 back-to-back, heap replying one cycle after each issue with sizes 1,2,3 → three `hp_in_v` pulses with `hp_vrd1`=000, tags 0,1,2, `hp_in_data` 10,20,15; three responses with err=0, data 0; `heap_count`=3.
- Then pop; heap returns data 20, size 2 → `hp_vrd1`=001, `hp_in_heap_size`=3, tag 3; `rsp_data`=20, err=0; `heap_count`=2.
- Pop after reset → no `hp_in_v`; `rsp_v` at N+3 with err=1, data 0. Push with `HEAP_CAP`=2 after two pushes → err=1, no issue.
- Heap never answers (`TIMEOUT`=15) → `rsp_err`=1 sixteen cycles after issue; `heap_count` unchanged; completion with tag mismatch ignored.
- Hold `rsp_ready`=0 while issuing five requests with `DEPTH`=4 → `req_ready` drops after the FIFO fills, response held stable. Releasing it drains all entries in order; 33 operations show tag wrap 31→0.
- Assert `reset` during WAIT → next cycle all outputs at reset values, FIFO empty. A stale `hp_out_v` then produces no response.
